// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter.
package wb_pkg;

  localparam int unsigned WB_WIDTH = 32;

  // Architectural zero register; writes to it are discarded.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // WB_WIDTH is the data width of this bundle. A top-level WIDTH override must match it.
  typedef struct packed {
    logic                valid;
    logic [4:0]          addr;
    logic [WB_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_bank_queue.sv
// In-order write-back queue for one register-file bank. It takes up to two pushes and one
// pop per cycle, and searches all four read ports for the youngest matching queued entry.
module wb_bank_queue
  import wb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic        BANK  = 1'b0,
  localparam int unsigned IdxW = $clog2(DEPTH),
  localparam int unsigned PtrW = IdxW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push0_valid,
  input  logic [4:0]         push0_addr,
  input  logic [WIDTH-1:0]   push0_data,
  input  logic               push1_valid,
  input  logic [4:0]         push1_addr,
  input  logic [WIDTH-1:0]   push1_data,
  input  logic               pop,
  output logic [PtrW-1:0]    count,
  output logic [4:0]         head_addr,
  output logic [WIDTH-1:0]   head_data,
  input  logic [19:0]        ra_flat,
  output logic [3:0]         fwd_hit,
  output logic [4*WIDTH-1:0] fwd_data_flat
);

  logic [4:0]       addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IdxW-1:0]  wr_idx0, wr_idx1, rd_idx;

  assign wr_idx0   = wr_ptr_q[IdxW-1:0];
  assign wr_idx1   = wr_idx0 + IdxW'(1);
  assign rd_idx    = rd_ptr_q[IdxW-1:0];
  assign count     = wr_ptr_q - rd_ptr_q;
  assign head_addr = addr_q[rd_idx];
  assign head_data = data_q[rd_idx];

  // Pointer advance: push0 always fills first, so push1 lands one slot later.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push0_valid) + PtrW'(push1_valid);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
  end

  // Pointer registers; reset empties the queue and discards its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; needs no reset because validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push0_valid) begin
      addr_q[wr_idx0] <= push0_addr;
      data_q[wr_idx0] <= push0_data;
    end
    if (push1_valid) begin
      addr_q[wr_idx1] <= push1_addr;
      data_q[wr_idx1] <= push1_data;
    end
  end

  // Forwarding search: walk oldest to youngest so the last match wins.
  always_comb begin
    logic [4:0]      ra;
    logic [PtrW-1:0] slot;
    fwd_hit       = '0;
    fwd_data_flat = '0;
    ra            = '0;
    slot          = '0;
    for (int k = 0; k < 4; k++) begin
      ra = ra_flat[k*5 +: 5];
      for (int i = 0; i < DEPTH; i++) begin
        slot = rd_ptr_q + PtrW'(i);
        if ((PtrW'(i) < count) && (ra != REG_ZERO) && (ra[0] == BANK) &&
            (addr_q[slot[IdxW-1:0]] == ra)) begin
          fwd_hit[k]                      = 1'b1;
          fwd_data_flat[k*WIDTH +: WIDTH] = data_q[slot[IdxW-1:0]];
        end
      end
    end
  end

endmodule

// File: rtl/wb_bank_arbiter.sv
// Steers two write-back requests per cycle onto the even and odd register-file write
// ports. Per-bank queues absorb collisions and backlog, and queued data is forwarded
// to the read ports.
module wb_bank_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned WIDTH = WB_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w0_valid_i,
  input  logic [4:0]       w0_addr_i,
  input  logic [WIDTH-1:0] w0_data_i,
  input  logic             w1_valid_i,
  input  logic [4:0]       w1_addr_i,
  input  logic [WIDTH-1:0] w1_data_i,
  output logic             ready_o,
  output logic             we_even_o,
  output logic [4:0]       wa_even_o,
  output logic [WIDTH-1:0] wd_even_o,
  output logic             we_odd_o,
  output logic [4:0]       wa_odd_o,
  output logic [WIDTH-1:0] wd_odd_o,
  input  logic [4:0]       ra0_i,
  input  logic [4:0]       ra1_i,
  input  logic [4:0]       ra2_i,
  input  logic [4:0]       ra3_i,
  output logic [3:0]       fwd_hit_o,
  output logic [WIDTH-1:0] fwd_data0_o,
  output logic [WIDTH-1:0] fwd_data1_o,
  output logic [WIDTH-1:0] fwd_data2_o,
  output logic [WIDTH-1:0] fwd_data3_o,
  output logic             drained_o
);

  localparam int unsigned PtrW = $clog2(DEPTH) + 1;

  wb_req_t          req0, req1;
  logic [PtrW-1:0]  cnt       [2];
  logic [4:0]       head_addr [2];
  logic [WIDTH-1:0] head_data [2];
  logic             cand0 [2], cand1 [2];
  logic             we    [2], pop [2], p0_v [2], p1_v [2];
  logic [4:0]       wa    [2], p0_a [2], p1_a [2];
  logic [WIDTH-1:0] wd    [2], p0_d [2], p1_d [2];
  logic [3:0]         hit_even, hit_odd;
  logic [4*WIDTH-1:0] fwd_even, fwd_odd;
  logic [19:0]        ra_flat;

  // Two free slots per bank guarantee that a full pair fits wherever it lands.
  assign ready_o   = (cnt[0] <= PtrW'(DEPTH - 2)) && (cnt[1] <= PtrW'(DEPTH - 2));
  assign drained_o = (cnt[0] == '0) && (cnt[1] == '0);

  // Acceptance: r0 writes are dropped, and nothing is taken while reset is asserted.
  always_comb begin
    req0       = '0;
    req1       = '0;
    req0.valid = w0_valid_i & ready_o & ~rst & (w0_addr_i != REG_ZERO);
    req0.addr  = w0_addr_i;
    req0.data  = w0_data_i;
    req1.valid = w1_valid_i & ready_o & ~rst & (w1_addr_i != REG_ZERO);
    req1.addr  = w1_addr_i;
    req1.data  = w1_data_i;
  end

  // Per bank: issue the oldest candidate (queue head, then w0, then w1); enqueue the rest.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      cand0[b] = req0.valid && (req0.addr[0] == 1'(b));
      cand1[b] = req1.valid && (req1.addr[0] == 1'(b));
      we[b]    = 1'b0;
      wa[b]    = '0;
      wd[b]    = '0;
      pop[b]   = 1'b0;
      p0_v[b]  = 1'b0;
      p0_a[b]  = '0;
      p0_d[b]  = '0;
      p1_v[b]  = 1'b0;
      p1_a[b]  = '0;
      p1_d[b]  = '0;
      if (cnt[b] != '0) begin
        we[b]  = 1'b1;
        wa[b]  = head_addr[b];
        wd[b]  = head_data[b];
        pop[b] = 1'b1;
        if (cand0[b]) begin
          p0_v[b] = 1'b1;
          p0_a[b] = req0.addr;
          p0_d[b] = req0.data;
          p1_v[b] = cand1[b];
          p1_a[b] = cand1[b] ? req1.addr : 5'd0;
          p1_d[b] = cand1[b] ? req1.data : '0;
        end else if (cand1[b]) begin
          p0_v[b] = 1'b1;
          p0_a[b] = req1.addr;
          p0_d[b] = req1.data;
        end
      end else if (cand0[b]) begin
        we[b] = 1'b1;
        wa[b] = req0.addr;
        wd[b] = req0.data;
        if (cand1[b]) begin
          p0_v[b] = 1'b1;
          p0_a[b] = req1.addr;
          p0_d[b] = req1.data;
        end
      end else if (cand1[b]) begin
        we[b] = 1'b1;
        wa[b] = req1.addr;
        wd[b] = req1.data;
      end
    end
  end

  assign we_even_o = we[0];
  assign wa_even_o = wa[0];
  assign wd_even_o = wd[0];
  assign we_odd_o  = we[1];
  assign wa_odd_o  = wa[1];
  assign wd_odd_o  = wd[1];

  assign ra_flat = {ra3_i, ra2_i, ra1_i, ra0_i};

  wb_bank_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BANK(1'b0)) u_q_even (
    .clk          (clk),
    .rst          (rst),
    .push0_valid  (p0_v[0]),
    .push0_addr   (p0_a[0]),
    .push0_data   (p0_d[0]),
    .push1_valid  (p1_v[0]),
    .push1_addr   (p1_a[0]),
    .push1_data   (p1_d[0]),
    .pop          (pop[0]),
    .count        (cnt[0]),
    .head_addr    (head_addr[0]),
    .head_data    (head_data[0]),
    .ra_flat      (ra_flat),
    .fwd_hit      (hit_even),
    .fwd_data_flat(fwd_even)
  );

  wb_bank_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BANK(1'b1)) u_q_odd (
    .clk          (clk),
    .rst          (rst),
    .push0_valid  (p0_v[1]),
    .push0_addr   (p0_a[1]),
    .push0_data   (p0_d[1]),
    .push1_valid  (p1_v[1]),
    .push1_addr   (p1_a[1]),
    .push1_data   (p1_d[1]),
    .pop          (pop[1]),
    .count        (cnt[1]),
    .head_addr    (head_addr[1]),
    .head_data    (head_data[1]),
    .ra_flat      (ra_flat),
    .fwd_hit      (hit_odd),
    .fwd_data_flat(fwd_odd)
  );

  // Each queue only answers lookups for its own bank, so OR-merging is exact.
  assign fwd_hit_o   = hit_even | hit_odd;
  assign fwd_data0_o = fwd_even[0*WIDTH +: WIDTH] | fwd_odd[0*WIDTH +: WIDTH];
  assign fwd_data1_o = fwd_even[1*WIDTH +: WIDTH] | fwd_odd[1*WIDTH +: WIDTH];
  assign fwd_data2_o = fwd_even[2*WIDTH +: WIDTH] | fwd_odd[2*WIDTH +: WIDTH];
  assign fwd_data3_o = fwd_even[3*WIDTH +: WIDTH] | fwd_odd[3*WIDTH +: WIDTH];

endmodule
